machine_timer: RTL and testbench

MACHINE_TIMER -- requirements
Module: machine_timer

---
 rtl/machine_timer.sv | 132 +++++++++++++
 tb/tb_machine_timer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_timer.sv
// Memory-mapped 64-bit machine timer: prescaled mtime counter, mtimecmp compare
// with a DISARMED/ARMED/FIRED interrupt FSM, and a registered read port.
module machine_timer #(
    parameter int PRESCALE_DIV = 1,
    parameter int X_LEN        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_en,
    input  logic             timer_wr_en,
    input  logic [1:0]       timer_addr,
    input  logic [X_LEN-1:0] timer_wr_data,
    input  logic             timer_rd_en,
    output logic [X_LEN-1:0] timer_rd_data,
    output logic             timer_rd_valid,
    output logic             timer_timeout,
    output logic             timer_armed,
    output logic [1:0]       dbg_state
);

    localparam int PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE_DIV - 1);
    localparam logic [PW-1:0] PS_ONE = PW'(1);
    localparam logic [2*X_LEN-1:0] MT_ONE = (2*X_LEN)'(1);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        FIRED    = 2'd2
    } state_t;

    state_t             state;
    logic [2*X_LEN-1:0] mtime;
    logic [2*X_LEN-1:0] mtimecmp;
    logic [PW-1:0]      prescaler;
    logic [X_LEN-1:0]   shadow_hi;
    logic               lo_read_q;

    logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, tick;

    assign wr_mtime_lo = timer_wr_en && (timer_addr == 2'd0);
    assign wr_mtime_hi = timer_wr_en && (timer_addr == 2'd1);
    assign wr_cmp_lo   = timer_wr_en && (timer_addr == 2'd2);
    assign wr_cmp_hi   = timer_wr_en && (timer_addr == 2'd3);
    assign tick        = count_en && (prescaler == PS_MAX);
    assign dbg_state   = state;

    // Software writes to mtime win over a due increment and restart the prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime     <= '0;
            prescaler <= '0;
        end else if (wr_mtime_lo || wr_mtime_hi) begin
            prescaler <= '0;
            if (wr_mtime_lo)
                mtime[X_LEN-1:0] <= timer_wr_data;
            else
                mtime[2*X_LEN-1:X_LEN] <= timer_wr_data;
        end else if (count_en) begin
            if (tick) begin
                prescaler <= '0;
                mtime     <= mtime + MT_ONE;
            end else begin
                prescaler <= prescaler + PS_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtimecmp <= '1;
        end else if (wr_cmp_lo) begin
            mtimecmp[X_LEN-1:0] <= timer_wr_data;
        end else if (wr_cmp_hi) begin
            mtimecmp[2*X_LEN-1:X_LEN] <= timer_wr_data;
        end
    end

    // Writing the low compare half disarms so a half-updated value can never fire;
    // the high-half write re-arms.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= DISARMED;
            timer_armed   <= 1'b0;
            timer_timeout <= 1'b0;
        end else if (wr_cmp_lo) begin
            state         <= DISARMED;
            timer_armed   <= 1'b0;
            timer_timeout <= 1'b0;
        end else if (wr_cmp_hi) begin
            state         <= ARMED;
            timer_armed   <= 1'b1;
            timer_timeout <= 1'b0;
        end else begin
            case (state)
                ARMED: begin
                    if (mtime >= mtimecmp) begin
                        state         <= FIRED;
                        timer_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read port: timer_rd_en is always accepted (no back-pressure); timer_rd_valid
    // pulses for exactly one cycle, the cycle after the request, with the data.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_rd_data  <= '0;
            timer_rd_valid <= 1'b0;
            shadow_hi      <= '0;
            lo_read_q      <= 1'b0;
        end else begin
            timer_rd_valid <= timer_rd_en;
            lo_read_q      <= timer_rd_en && (timer_addr == 2'd0);
            if (timer_rd_en) begin
                case (timer_addr)
                    2'd0: begin
                        timer_rd_data <= mtime[X_LEN-1:0];
                        shadow_hi     <= mtime[2*X_LEN-1:X_LEN];
                    end
                    2'd1:    timer_rd_data <= lo_read_q ? shadow_hi : mtime[2*X_LEN-1:X_LEN];
                    2'd2:    timer_rd_data <= mtimecmp[X_LEN-1:0];
                    default: timer_rd_data <= mtimecmp[2*X_LEN-1:X_LEN];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: a register table plus hand-written sequences,
// run on a PRESCALE_DIV=1 instance and a PRESCALE_DIV=4 instance sharing inputs.
module tb_machine_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        count_en = 1'b0;
    logic        timer_wr_en = 1'b0;
    logic [1:0]  timer_addr = 2'd0;
    logic [31:0] timer_wr_data = 32'd0;
    logic        timer_rd_en = 1'b0;

    logic [31:0] rd_data1, rd_data4;
    logic        rd_valid1, rd_valid4, timeout1, timeout4, armed1, armed4;
    logic [1:0]  state1, state4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    machine_timer #(.PRESCALE_DIV(1), .X_LEN(32)) u_dut1 (
        .clk(clk), .reset(reset), .count_en(count_en), .timer_wr_en(timer_wr_en),
        .timer_addr(timer_addr), .timer_wr_data(timer_wr_data), .timer_rd_en(timer_rd_en),
        .timer_rd_data(rd_data1), .timer_rd_valid(rd_valid1), .timer_timeout(timeout1),
        .timer_armed(armed1), .dbg_state(state1)
    );

    machine_timer #(.PRESCALE_DIV(4), .X_LEN(32)) u_dut4 (
        .clk(clk), .reset(reset), .count_en(count_en), .timer_wr_en(timer_wr_en),
        .timer_addr(timer_addr), .timer_wr_data(timer_wr_data), .timer_rd_en(timer_rd_en),
        .timer_rd_data(rd_data4), .timer_rd_valid(rd_valid4), .timer_timeout(timeout4),
        .timer_armed(armed4), .dbg_state(state4)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic [31:0] data;
        logic        valid;
        logic [31:0] rdata;
        logic        armed;
        logic        tmo;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        timer_wr_en   = 1'b1;
        timer_addr    = a;
        timer_wr_data = d;
        step();
        timer_wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        timer_rd_en = 1'b1;
        timer_addr  = a;
        step();
        timer_rd_en = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        vecs[0]  = '{1'b0, 1'b1, 2'd2, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd3, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'd2, 32'h20,        1'b0, 32'h0,         1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2'd3, 32'h1,         1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'd3, 32'h0,         1'b1, 32'h1,         1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd0, 32'hDEAD_BEEF, 1'b1, 32'h0,         1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 2'd1, 32'h2,         1'b1, 32'h0,         1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 2'd1, 32'h0,         1'b1, 32'h2,         1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 32'h0,         1'b0, 32'h2,         1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 2'd2, 32'h40,        1'b0, 32'h2,         1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 2'd2, 32'h0,         1'b1, 32'h40,        1'b0, 1'b0};

        // Reset state
        run_cycles(2);
        reset = 1'b0;
        check("reset_timeout", {63'd0, timeout1}, 64'd0);
        check("reset_armed", {63'd0, armed1}, 64'd0);
        check("reset_rd_valid", {63'd0, rd_valid1}, 64'd0);
        check("reset_rd_data", {32'd0, rd_data1}, 64'd0);
        check("reset_state", {62'd0, state1}, 64'd0);

        // Register table, counting disabled
        for (int i = 0; i < 14; i++) begin
            timer_wr_en   = vecs[i].wr;
            timer_rd_en   = vecs[i].rd;
            timer_addr    = vecs[i].addr;
            timer_wr_data = vecs[i].data;
            step();
            timer_wr_en = 1'b0;
            timer_rd_en = 1'b0;
            check($sformatf("vec%0d_valid", i), {63'd0, rd_valid1}, {63'd0, vecs[i].valid});
            check($sformatf("vec%0d_rdata", i), {32'd0, rd_data1}, {32'd0, vecs[i].rdata});
            check($sformatf("vec%0d_armed", i), {63'd0, armed1}, {63'd0, vecs[i].armed});
            check($sformatf("vec%0d_tmo", i), {63'd0, timeout1}, {63'd0, vecs[i].tmo});
            check($sformatf("vec%0d_rdata4", i), {32'd0, rd_data4}, {32'd0, vecs[i].rdata});
            check($sformatf("vec%0d_tmo4", i), {63'd0, timeout4}, {63'd0, vecs[i].tmo});
        end

        // Compare at 10, interrupt one cycle after mtime reaches it
        do_reset();
        wr(2'd2, 32'd10);
        check("cmp_lo_armed", {63'd0, armed1}, 64'd0);
        wr(2'd3, 32'd0);
        check("cmp_hi_armed", {63'd0, armed1}, 64'd1);
        count_en = 1'b1;
        n = 0;
        while (!timeout1 && n < 50) begin
            step();
            n++;
        end
        count_en = 1'b0;
        check("fire_latency_10", n, 11);
        check("fired_state", {62'd0, state1}, 64'd2);
        rd(2'd0);
        check("mtime_after_fire", {32'd0, rd_data1}, 64'd11);

        // Rewrite compare while FIRED
        wr(2'd2, 32'd100);
        check("rearm_lo_tmo", {63'd0, timeout1}, 64'd0);
        check("rearm_lo_armed", {63'd0, armed1}, 64'd0);
        wr(2'd3, 32'd0);
        check("rearm_hi_armed", {63'd0, armed1}, 64'd1);
        check("rearm_hi_tmo", {63'd0, timeout1}, 64'd0);
        count_en = 1'b1;
        n = 0;
        while (!timeout1 && n < 200) begin
            step();
            n++;
        end
        count_en = 1'b0;
        check("fire_latency_100", n, 90);

        // Low/high carry and shadowed high read
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'h0);
        count_en    = 1'b1;
        timer_rd_en = 1'b1;
        timer_addr  = 2'd0;
        step();
        count_en    = 1'b0;
        timer_rd_en = 1'b0;
        check("shadow_lo", {32'd0, rd_data1}, 64'h0000_0000_FFFF_FFFF);
        rd(2'd1);
        check("shadow_hi", {32'd0, rd_data1}, 64'd0);
        rd(2'd1);
        check("live_hi_carry", {32'd0, rd_data1}, 64'd1);

        // mtime write wins over a due increment and clears the prescaler
        do_reset();
        count_en = 1'b1;
        run_cycles(3);
        wr(2'd0, 32'd5);
        count_en = 1'b0;
        rd(2'd0);
        check("wr_prio_div1", {32'd0, rd_data1}, 64'd5);
        check("wr_prio_div4", {32'd0, rd_data4}, 64'd5);
        count_en = 1'b1;
        run_cycles(3);
        count_en = 1'b0;
        rd(2'd0);
        check("ps_cleared_div4", {32'd0, rd_data4}, 64'd5);
        count_en = 1'b1;
        run_cycles(1);
        count_en = 1'b0;
        rd(2'd0);
        check("ps_wrap_div4", {32'd0, rd_data4}, 64'd6);

        // Prescaled counting, hold while disabled, prescaler resumes
        do_reset();
        count_en = 1'b1;
        run_cycles(20);
        count_en = 1'b0;
        run_cycles(10);
        rd(2'd0);
        check("div4_20cyc", {32'd0, rd_data4}, 64'd5);
        check("div1_20cyc", {32'd0, rd_data1}, 64'd20);
        count_en = 1'b1;
        run_cycles(2);
        count_en = 1'b0;
        run_cycles(2);
        count_en = 1'b1;
        run_cycles(2);
        count_en = 1'b0;
        rd(2'd0);
        check("div4_resume", {32'd0, rd_data4}, 64'd6);

        // Reset while FIRED, with a concurrent read and compare write
        wr(2'd0, 32'h1234);
        wr(2'd1, 32'h0);
        wr(2'd2, 32'h1000);
        wr(2'd3, 32'h0);
        step();
        check("pre_reset_fired", {63'd0, timeout1}, 64'd1);
        reset         = 1'b1;
        timer_rd_en   = 1'b1;
        timer_wr_en   = 1'b1;
        timer_addr    = 2'd3;
        timer_wr_data = 32'h0;
        step();
        reset       = 1'b0;
        timer_rd_en = 1'b0;
        timer_wr_en = 1'b0;
        check("rst_fired_tmo", {63'd0, timeout1}, 64'd0);
        check("rst_fired_armed", {63'd0, armed1}, 64'd0);
        check("rst_fired_valid", {63'd0, rd_valid1}, 64'd0);
        check("rst_fired_rdata", {32'd0, rd_data1}, 64'd0);
        check("rst_fired_state", {62'd0, state1}, 64'd0);
        rd(2'd0);
        check("rst_mtime_lo", {32'd0, rd_data1}, 64'd0);
        rd(2'd2);
        check("rst_cmp_lo", {32'd0, rd_data1}, 64'hFFFF_FFFF);
        rd(2'd3);
        check("rst_cmp_hi", {32'd0, rd_data1}, 64'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
